clock_control: RTL and testbench
================================

# clock_control

Front-end conditioner for the CPU clock generator. Takes two raw, bouncing, asynchronous push-buttons (step and mode) and turns them into the clean `mode` level and `manual_toggle` waveform consumed by the clock mux. The mux selects between the free-running divided clock and the manual clock. In manual mode each debounced step press produces exactly one fixed-width high pulse on `manual_toggle`, i.e. exactly one CPU clock cycle.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive `sys_clk` cycles a synchronized button must hold a new level before the level is accepted; min 2.
- `PULSE_CYCLES`, default 1000: high time of one step pulse on `manual_toggle`, in `sys_clk` cycles; min 1.
- `HOLD_CYCLES`, default 25000000: step-button hold time before auto-repeat starts. Used only with `STEP_REPEAT_EN`.
- `REPEAT_CYCLES`, default 5000000: pulse period during auto-repeat, measured start to start; must exceed `PULSE_CYCLES`. Used only with `STEP_REPEAT_EN`.
- `sys_clk` input 1: system clock, sole clock domain.
- `rst` input 1: synchronous, active-high reset.
- `step_btn` input 1: raw step button, active-high, asynchronous.
- `mode_btn` input 1: raw mode button, active-high, asynchronous.
- `mode` output 1: 0 = continuous, 1 = manual; drives the clock mux select.
- `manual_toggle` output 1: manual clock level.
- `step_busy` output 1: high while a pulse is being emitted (state `PULSE`).

## Operation
- **Synchronizer.** Each button passes through a 2-flop synchronizer, reset to 0.
- **Debouncer (one per button).**
  - Each debouncer holds a `stable` bit (reset 0) and a counter of width `$clog2(DEBOUNCE_CYCLES)`.
  - When the synchronized value equals `stable`, the counter clears.
  - Otherwise the counter increments. In the cycle it reaches `DEBOUNCE_CYCLES-1`, `stable` flips and the counter clears.
  - A `press` strobe is asserted for one cycle when `stable` goes 0→1. Releases produce no strobe.
- **Mode.** `mode` toggles on each `mode` press strobe. Reset value 0.
- **Step FSM.** States are `IDLE`, `PULSE`, `HOLD`.
  - `IDLE`: `manual_toggle`=0. A step press strobe with `mode`=1 moves to `PULSE` and loads the pulse counter. A step press with `mode`=0 is discarded.
  - `PULSE`: `manual_toggle`=1 for exactly `PULSE_CYCLES` cycles, then go to `HOLD`.
  - `HOLD`: `manual_toggle`=0. Stay until the debounced step level is 0, then go to `IDLE`. A button held down therefore yields one pulse only.
- **Presses while busy.** Press strobes arriving in `PULSE` or `HOLD` are ignored; they are not queued.
- **Mode change.**
  - If `mode` goes 0 while in `PULSE`, the FSM goes to `HOLD` next cycle and `manual_toggle` drops to 0 immediately. There is no truncation glitch beyond a shortened high time.
  - If mode and step strobes occur in the same cycle, step is evaluated against the pre-toggle `mode` value.
- **Reset.** `rst` mid-operation returns everything to reset state at the next edge.
- **Reset values.** `mode`=0, `manual_toggle`=0, `step_busy`=0, FSM=`IDLE`, all counters 0.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Raw button rising at edge k (first edge sampling 1, held clean):
  - Synchronized value is valid at edge k+2.
  - `stable` and the press strobe are set at edge k+1+`DEBOUNCE_CYCLES`.
  - `mode` toggles, or `manual_toggle` rises, at edge k+2+`DEBOUNCE_CYCLES`.
- A bounce (synchronized value returning to `stable`) restarts the count from zero.
- `manual_toggle` high time is exactly `PULSE_CYCLES` `sys_clk` cycles unless aborted by a mode change.
- Minimum low time is governed by the button release plus debounce.

## Configuration
- **Macro: `STEP_REPEAT_EN`.**
- **Defined:**
  - In `HOLD`, a hold counter runs while the debounced step level is 1.
  - After `HOLD_CYCLES` cycles counted from the first pulse's rising edge, a new `PULSE` starts.
  - Subsequent pulses start every `REPEAT_CYCLES` cycles while the button stays held and `mode`=1.
  - Release returns to `IDLE` after the current pulse completes.
- **Undefined:** repeat counters and logic are absent; one pulse per press, exactly as above.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `PULSE_CYCLES`=3, `HOLD_CYCLES`=20, `REPEAT_CYCLES`=10.

- **Reset.** Assert `rst` for 2 cycles with both buttons 1 → `mode`=0, `manual_toggle`=0, `step_busy`=0 in the cycle after release; no strobe until 4 stable cycles have elapsed.
- **Bounce rejection.** `mode_btn` toggles 1,0,1,0,1 on successive cycles, then stays 1 → `mode` becomes 1 exactly 6 edges after the final rise; a single toggle only.
- **Single step.** `mode`=1; hold `step_btn` high for 50 cycles → exactly one `manual_toggle` high of 3 cycles, rising 6 edges after the button edge. Without `STEP_REPEAT_EN`, no further pulses.
- **Step in continuous mode.** `mode`=0; press step → `manual_toggle` stays 0, FSM stays `IDLE`.
- **Abort.** Press step, then a mode press whose strobe lands in cycle 2 of `PULSE` → `manual_toggle` falls the next cycle, `mode`=0, and the FSM reaches `IDLE` after step release.
- **Auto-repeat (with `STEP_REPEAT_EN`).** Hold step 60 cycles in manual mode → pulses start at offsets 0, 20, 30, 40, 50 from the first rise, each 3 cycles high; no pulse after release.

Source files
------------

// File: rtl/clock_control.sv
// rtl/clock_control.sv - debounced step/mode button conditioner for the CPU clock mux
//
// Optional feature macro: STEP_REPEAT_EN (step auto-repeat while the button is held).
//
// Ports (clock_control):
//   sys_clk        system clock, sole clock domain
//   rst            synchronous active-high reset
//   step_btn       raw step button, active-high, asynchronous
//   mode_btn       raw mode button, active-high, asynchronous
//   mode           0 = continuous, 1 = manual (clock mux select)
//   manual_toggle  manual clock level, one fixed-width high pulse per step
//   step_busy      high while a step pulse is being emitted
//
// Ports (clock_control_sync):
//   sys_clk, rst   clock and synchronous active-high reset
//   async_level    asynchronous level to be synchronized
//   sync_level     level after two flops

module clock_control_sync (
    input  logic sys_clk,
    input  logic rst,
    input  logic async_level,
    output logic sync_level
);

    logic meta;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            meta       <= 1'b0;
            sync_level <= 1'b0;
        end else begin
            meta       <= async_level;
            sync_level <= meta;
        end
    end

endmodule

module clock_control #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int PULSE_CYCLES    = 1000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic step_btn,
    input  logic mode_btn,
    output logic mode,
    output logic manual_toggle,
    output logic step_busy
);

    if (DEBOUNCE_CYCLES < 2 || PULSE_CYCLES < 1 || HOLD_CYCLES < 1 ||
        REPEAT_CYCLES <= PULSE_CYCLES) begin : g_bad_params
        $error("clock_control: illegal timing parameters");
    end

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYCLES - 1);

`ifdef STEP_REPEAT_EN
    localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RW = $clog2(RMAX + 1);
    localparam logic [RW-1:0] HOLD_LOAD   = RW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REPEAT_LOAD = RW'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } step_state_t;

    // Button index 0 = step, 1 = mode.
    logic [1:0]    btn_sync;
    logic [1:0]    btn_stable;
    logic [1:0]    btn_press;
    logic [CW-1:0] db_cnt [2];

    step_state_t   state;
    logic [PW-1:0] pulse_cnt;
`ifdef STEP_REPEAT_EN
    logic [RW-1:0] rep_cnt;
`endif

    logic step_press;
    logic step_level;
    logic mode_press;
    logic mode_next;

    clock_control_sync u_sync_step (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .async_level(step_btn),
        .sync_level (btn_sync[0])
    );

    clock_control_sync u_sync_mode (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .async_level(mode_btn),
        .sync_level (btn_sync[1])
    );

    // Debounce: a new level must be seen for DEBOUNCE_CYCLES consecutive
    // samples; any sample matching the accepted level restarts the count.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            btn_stable <= '0;
            btn_press  <= '0;
            for (int b = 0; b < 2; b++) begin
                db_cnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                btn_press[b] <= 1'b0;
                if (btn_sync[b] == btn_stable[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == DB_LAST) begin
                    btn_stable[b] <= ~btn_stable[b];
                    db_cnt[b]     <= '0;
                    // strobe only on an accepted 0->1 transition
                    btn_press[b]  <= ~btn_stable[b];
                end else begin
                    db_cnt[b] <= db_cnt[b] + 1'b1;
                end
            end
        end
    end

    assign step_press = btn_press[0];
    assign step_level = btn_stable[0];
    assign mode_press = btn_press[1];

    // Value mode takes at the coming edge; lets a pulse be cut in the same
    // edge that mode drops so the two outputs fall together.
    assign mode_next = mode ^ mode_press;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            mode <= 1'b0;
        end else begin
            mode <= mode_next;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state         <= IDLE;
            manual_toggle <= 1'b0;
            step_busy     <= 1'b0;
            pulse_cnt     <= '0;
`ifdef STEP_REPEAT_EN
            rep_cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // judged against the pre-toggle mode value
                    if (step_press && mode) begin
                        state         <= PULSE;
                        manual_toggle <= 1'b1;
                        step_busy     <= 1'b1;
                        pulse_cnt     <= PULSE_LOAD;
`ifdef STEP_REPEAT_EN
                        rep_cnt       <= HOLD_LOAD;
`endif
                    end
                end

                PULSE: begin
`ifdef STEP_REPEAT_EN
                    if (rep_cnt != '0) begin
                        rep_cnt <= rep_cnt - 1'b1;
                    end
`endif
                    if (!mode_next || pulse_cnt == '0) begin
                        state         <= HOLD;
                        manual_toggle <= 1'b0;
                        step_busy     <= 1'b0;
                        pulse_cnt     <= '0;
                    end else begin
                        pulse_cnt <= pulse_cnt - 1'b1;
                    end
                end

                HOLD: begin
                    if (!step_level) begin
                        state <= IDLE;
`ifdef STEP_REPEAT_EN
                        rep_cnt <= '0;
`endif
                    end
`ifdef STEP_REPEAT_EN
                    // repeat timer runs from the previous pulse's rising edge
                    else if (rep_cnt != '0) begin
                        rep_cnt <= rep_cnt - 1'b1;
                    end else if (mode) begin
                        state         <= PULSE;
                        manual_toggle <= 1'b1;
                        step_busy     <= 1'b1;
                        pulse_cnt     <= PULSE_LOAD;
                        rep_cnt       <= REPEAT_LOAD;
                    end
`endif
                end

                default: begin
                    state         <= IDLE;
                    manual_toggle <= 1'b0;
                    step_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_control.sv
// tb/tb_clock_control.sv - directed vector bench for clock_control

module tb_clock_control;

    logic sys_clk = 1'b0;
    logic rst = 1'b1;
    logic step_btn = 1'b0;
    logic mode_btn = 1'b0;
    logic mode;
    logic manual_toggle;
    logic step_busy;

    int errors = 0;
    int checks = 0;

    clock_control #(
        .DEBOUNCE_CYCLES(4),
        .PULSE_CYCLES   (3),
        .HOLD_CYCLES    (20),
        .REPEAT_CYCLES  (10)
    ) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .step_btn     (step_btn),
        .mode_btn     (mode_btn),
        .mode         (mode),
        .manual_toggle(manual_toggle),
        .step_busy    (step_busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic r;
        logic sb;
        logic mb;
        int   n;
        logic em;
        logic et;
        logic eb;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic sb, input logic mb, input int n,
                       input logic em, input logic et, input logic eb);
        vec_t v;
        v.r = r; v.sb = sb; v.mb = mb; v.n = n;
        v.em = em; v.et = et; v.eb = eb;
        tbl.push_back(v);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit
    // after the rising edge that first sampled them.
    task automatic drive(input logic r, input logic sb, input logic mb);
        @(negedge sys_clk);
        rst      = r;
        step_btn = sb;
        mode_btn = mb;
        @(posedge sys_clk);
        #1;
    endtask

    localparam int MAXC = 100;
    logic hist [MAXC];
    int   exp_rise[$];
    int   got_rise[$];
    int   got_len[$];
    int   hold_n;
    int   len;

    initial begin
        // reset with both buttons pressed, then the held mode press toggles
        add(1, 1, 1,  2, 0, 0, 0);
        add(0, 1, 1,  6, 0, 0, 0);
        add(0, 1, 1,  4, 1, 0, 0);
        add(0, 0, 0,  8, 1, 0, 0);
        // bounce on mode: 1,0,1,0,1 then held, toggles 6 edges after last rise
        add(0, 0, 1,  1, 1, 0, 0);
        add(0, 0, 0,  1, 1, 0, 0);
        add(0, 0, 1,  1, 1, 0, 0);
        add(0, 0, 0,  1, 1, 0, 0);
        add(0, 0, 1,  6, 1, 0, 0);
        add(0, 0, 1,  4, 0, 0, 0);
        add(0, 0, 0,  8, 0, 0, 0);
        // step press in continuous mode is discarded
        add(0, 1, 0, 12, 0, 0, 0);
        add(0, 0, 0,  8, 0, 0, 0);
        // back to manual
        add(0, 0, 1,  6, 0, 0, 0);
        add(0, 0, 1,  4, 1, 0, 0);
        add(0, 0, 0,  8, 1, 0, 0);
        // single step: rises 6 edges after the button, high 3 cycles
        add(0, 1, 0,  6, 1, 0, 0);
        add(0, 1, 0,  3, 1, 1, 1);
        add(0, 1, 0, 10, 1, 0, 0);
        add(0, 0, 0, 10, 1, 0, 0);
        // abort: mode strobe lands in the second pulse cycle
        add(0, 1, 0,  2, 1, 0, 0);
        add(0, 1, 1,  4, 1, 0, 0);
        add(0, 1, 1,  2, 1, 1, 1);
        add(0, 1, 1,  4, 0, 0, 0);
        add(0, 0, 0, 10, 0, 0, 0);
        // manual again, then a step proves the FSM returned to idle
        add(0, 0, 1,  6, 0, 0, 0);
        add(0, 0, 1,  4, 1, 0, 0);
        add(0, 0, 0,  8, 1, 0, 0);
        add(0, 1, 0,  6, 1, 0, 0);
        add(0, 1, 0,  3, 1, 1, 1);
        add(0, 1, 0,  4, 1, 0, 0);
        add(0, 0, 0, 10, 1, 0, 0);
        // reset in the middle of a pulse
        add(0, 1, 0,  6, 1, 0, 0);
        add(0, 1, 0,  1, 1, 1, 1);
        add(1, 1, 0,  1, 0, 0, 0);
        add(0, 1, 0, 10, 0, 0, 0);
        add(0, 0, 0,  8, 0, 0, 0);
        // manual for the long hold sequence
        add(0, 0, 1,  6, 0, 0, 0);
        add(0, 0, 1,  4, 1, 0, 0);
        add(0, 0, 0,  8, 1, 0, 0);

        foreach (tbl[i]) begin
            for (int c = 0; c < tbl[i].n; c++) begin
                drive(tbl[i].r, tbl[i].sb, tbl[i].mb);
                checks++;
                if ({mode, manual_toggle, step_busy} !== {tbl[i].em, tbl[i].et, tbl[i].eb}) begin
                    errors++;
                    $display("FAIL vec row %0d cyc %0d: mode/toggle/busy got %b%b%b want %b%b%b",
                             i, c, mode, manual_toggle, step_busy,
                             tbl[i].em, tbl[i].et, tbl[i].eb);
                end
            end
        end

        // long hold in manual mode
`ifdef STEP_REPEAT_EN
        hold_n   = 60;
        exp_rise = '{6, 26, 36, 46, 56};
`else
        hold_n   = 50;
        exp_rise = '{6};
`endif
        for (int c = 0; c < hold_n + 20; c++) begin
            drive(1'b0, (c < hold_n), 1'b0);
            hist[c] = manual_toggle;
            checks++;
            if (step_busy !== manual_toggle || mode !== 1'b1) begin
                errors++;
                $display("FAIL hold cyc %0d: mode/toggle/busy got %b%b%b want 1 and busy==toggle",
                         c, mode, manual_toggle, step_busy);
            end
        end
        for (int c = 0; c < hold_n + 20; c++) begin
            if (hist[c] === 1'b1 && (c == 0 || hist[c-1] !== 1'b1)) begin
                len = 0;
                for (int j = c; j < hold_n + 20 && hist[j] === 1'b1; j++) len++;
                got_rise.push_back(c);
                got_len.push_back(len);
            end
        end
        checks++;
        if (got_rise.size() != exp_rise.size()) begin
            errors++;
            $display("FAIL hold pulse count: got %0d want %0d", got_rise.size(), exp_rise.size());
        end
        for (int i = 0; i < got_rise.size() && i < exp_rise.size(); i++) begin
            checks++;
            if (got_rise[i] != exp_rise[i]) begin
                errors++;
                $display("FAIL hold rise %0d: got offset %0d want %0d", i, got_rise[i], exp_rise[i]);
            end
            checks++;
            if (got_len[i] != 3) begin
                errors++;
                $display("FAIL hold width %0d: got %0d want 3", i, got_len[i]);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
